// File: rtl/sram_arbiter_if.sv
// Bundle of the fetch, data and SRAM-side signals around the shared-SRAM arbiter.
// slave is the arbiter's view; master is the CPU/SRAM environment's view.
interface sram_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              inst_req;
    logic [ADDR_W-1:0] inst_addr;
    logic              inst_addr_ok;
    logic              inst_data_ok;
    logic [DATA_W-1:0] inst_rdata;

    logic              data_req;
    logic              data_wr;
    logic [3:0]        data_wstrb;
    logic [ADDR_W-1:0] data_addr;
    logic [DATA_W-1:0] data_wdata;
    logic              data_addr_ok;
    logic              data_data_ok;
    logic [DATA_W-1:0] data_rdata;

    logic              sram_en;
    logic [3:0]        sram_we;
    logic [ADDR_W-1:0] sram_addr;
    logic [DATA_W-1:0] sram_wdata;
    logic [DATA_W-1:0] sram_rdata;

    modport slave (
        input  inst_req, inst_addr,
        output inst_addr_ok, inst_data_ok, inst_rdata,
        input  data_req, data_wr, data_wstrb, data_addr, data_wdata,
        output data_addr_ok, data_data_ok, data_rdata,
        output sram_en, sram_we, sram_addr, sram_wdata,
        input  sram_rdata
    );

    modport master (
        output inst_req, inst_addr,
        input  inst_addr_ok, inst_data_ok, inst_rdata,
        output data_req, data_wr, data_wstrb, data_addr, data_wdata,
        input  data_addr_ok, data_data_ok, data_rdata,
        input  sram_en, sram_we, sram_addr, sram_wdata,
        output sram_rdata
    );
endinterface

// File: rtl/sram_arbiter.sv
// Shares one single-port synchronous SRAM between instruction fetch and data access.
// Data side has priority; a starvation counter forces a fetch grant after STARVE_MAX denials.
module sram_arbiter #(
    parameter int unsigned STARVE_MAX = 4,
    parameter int          ADDR_W     = 32,
    parameter int          DATA_W     = 32
) (
    input logic          clk,
    input logic          resetn,
    sram_arbiter_if.slave bus
);
    localparam logic [2:0] STARVE_LIM = 3'(STARVE_MAX);

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_INST,
        OWN_DATA
    } owner_t;

    owner_t            resp_owner;
    logic [2:0]        starve_cnt;
    logic              gnt_inst;
    logic              gnt_data;
    logic [ADDR_W-1:0] gnt_addr;
    logic [DATA_W-1:0] gnt_wdata;

    always_comb begin
        gnt_data = resetn && bus.data_req && !(bus.inst_req && (starve_cnt == STARVE_LIM));
        gnt_inst = resetn && bus.inst_req && !gnt_data;
    end

    always_comb begin
        gnt_addr  = '0;
        gnt_wdata = '0;
        if (gnt_data) begin
            gnt_addr  = bus.data_addr;
            gnt_wdata = bus.data_wdata;
        end else if (gnt_inst) begin
            gnt_addr  = bus.inst_addr;
        end
    end

    always_comb begin
        bus.inst_addr_ok = gnt_inst;
        bus.data_addr_ok = gnt_data;
        bus.sram_en      = gnt_inst || gnt_data;
        bus.sram_addr    = gnt_addr;
        bus.sram_wdata   = gnt_wdata;
        bus.sram_we      = (gnt_data && bus.data_wr) ? bus.data_wstrb : '0;
    end

    // Responses follow the registered owner, so they are zero while in reset.
    always_comb begin
        bus.inst_data_ok = (resp_owner == OWN_INST);
        bus.data_data_ok = (resp_owner == OWN_DATA);
        bus.inst_rdata   = (resp_owner == OWN_INST) ? bus.sram_rdata : '0;
        bus.data_rdata   = (resp_owner == OWN_DATA) ? bus.sram_rdata : '0;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            resp_owner <= OWN_NONE;
            starve_cnt <= '0;
        end else begin
            if (gnt_inst)
                resp_owner <= OWN_INST;
            else if (gnt_data)
                resp_owner <= OWN_DATA;
            else
                resp_owner <= OWN_NONE;

            if (gnt_inst || !bus.inst_req)
                starve_cnt <= '0;
            else if (gnt_data && (starve_cnt != STARVE_LIM))
                starve_cnt <= starve_cnt + 3'd1;
        end
    end

    gnt_exclusive: assert property (@(posedge clk) disable iff (!resetn) !(gnt_inst && gnt_data));

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed and random-traffic bench for sram_arbiter with a behavioural 1-cycle SRAM.
module tb_sram_arbiter;
    logic clk = 1'b0;
    logic resetn;
    int   checks   = 0;
    int   failures = 0;

    logic [31:0] mem  [0:1023];
    logic [31:0] refm [0:1023];

    sram_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    sram_arbiter #(.STARVE_MAX(4), .ADDR_W(32), .DATA_W(32)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    // Synchronous SRAM model: byte writes, read data one cycle after enable.
    always @(posedge clk) begin
        if (bus.sram_en) begin
            if (bus.sram_we != 4'b0000) begin
                for (int b = 0; b < 4; b++)
                    if (bus.sram_we[b]) mem[bus.sram_addr[11:2]][8*b +: 8] = bus.sram_wdata[8*b +: 8];
            end else begin
                bus.sram_rdata <= mem[bus.sram_addr[11:2]];
            end
        end
    end

    function automatic logic [136:0] all_outputs();
        return {bus.inst_addr_ok, bus.inst_data_ok, bus.inst_rdata, bus.data_addr_ok,
                bus.data_data_ok, bus.data_rdata, bus.sram_en, bus.sram_we, bus.sram_addr, bus.sram_wdata};
    endfunction

    task automatic idle_inputs();
        bus.inst_req   = 1'b0;
        bus.inst_addr  = '0;
        bus.data_req   = 1'b0;
        bus.data_wr    = 1'b0;
        bus.data_wstrb = 4'b0000;
        bus.data_addr  = '0;
        bus.data_wdata = '0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        bus.sram_rdata = 32'h5A5A5A5A;
        bus.inst_req = 1'b1;  bus.inst_addr = 32'h1c000000;
        bus.data_req = 1'b1;  bus.data_wr = 1'b1; bus.data_wstrb = 4'hF;
        bus.data_addr = 32'h100; bus.data_wdata = 32'hFFFFFFFF;
        #3;
        checks++;
        if (all_outputs() !== '0) begin
            failures++; $display("FAIL reset_outputs got=%h exp=0", all_outputs());
        end
        @(posedge clk); #2;
        checks++;
        if (all_outputs() !== '0) begin
            failures++; $display("FAIL reset_outputs_after_edge got=%h exp=0", all_outputs());
        end
        next_cycle();
        resetn = 1'b1;
        idle_inputs();
        @(negedge clk);
        checks++;
        if (all_outputs() !== '0) begin
            failures++; $display("FAIL reset_release_idle got=%h exp=0", all_outputs());
        end
        checks++;
        if (dut.starve_cnt !== 3'd0) begin
            failures++; $display("FAIL reset_starve_cnt got=%0d exp=0", dut.starve_cnt);
        end
        next_cycle();
    endtask

    task automatic test_inst_fetch();
        logic [31:0] pre [3];
        pre[0] = 32'hA0A0A0A0; pre[1] = 32'hB1B1B1B1; pre[2] = 32'hC2C2C2C2;
        for (int i = 0; i < 3; i++) begin
            bus.inst_req  = 1'b1;
            bus.inst_addr = 32'h1c000000 + 32'(4 * i);
            @(negedge clk);
            checks++;
            if ({bus.inst_addr_ok, bus.data_addr_ok, bus.sram_en} !== 3'b101) begin
                failures++; $display("FAIL fetch_grant[%0d] got=%b exp=101", i, {bus.inst_addr_ok, bus.data_addr_ok, bus.sram_en});
            end
            checks++;
            if (bus.sram_addr !== bus.inst_addr || bus.sram_we !== 4'b0000) begin
                failures++; $display("FAIL fetch_sram_drive[%0d] addr=%h we=%b exp_addr=%h we=0", i, bus.sram_addr, bus.sram_we, bus.inst_addr);
            end
            if (i > 0) begin
                checks++;
                if (bus.inst_data_ok !== 1'b1 || bus.inst_rdata !== pre[i-1]) begin
                    failures++; $display("FAIL fetch_resp[%0d] ok=%b data=%h exp ok=1 data=%h", i - 1, bus.inst_data_ok, bus.inst_rdata, pre[i-1]);
                end
            end
            next_cycle();
        end
        bus.inst_req = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.inst_data_ok !== 1'b1 || bus.inst_rdata !== pre[2] || bus.sram_en !== 1'b0) begin
            failures++; $display("FAIL fetch_resp[2] ok=%b data=%h en=%b exp ok=1 data=%h en=0", bus.inst_data_ok, bus.inst_rdata, bus.sram_en, pre[2]);
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if (bus.inst_data_ok !== 1'b0) begin
            failures++; $display("FAIL fetch_resp_end got=%b exp=0", bus.inst_data_ok);
        end
        next_cycle();
    endtask

    task automatic test_write_read();
        bus.data_req = 1'b1; bus.data_wr = 1'b1; bus.data_wstrb = 4'b0011;
        bus.data_addr = 32'h100; bus.data_wdata = 32'hDEADBEEF;
        @(negedge clk);
        checks++;
        if ({bus.data_addr_ok, bus.sram_we, bus.sram_addr, bus.sram_wdata} !== {1'b1, 4'b0011, 32'h100, 32'hDEADBEEF}) begin
            failures++; $display("FAIL write_drive ok=%b we=%b addr=%h wdata=%h exp 1 0011 100 deadbeef",
                                 bus.data_addr_ok, bus.sram_we, bus.sram_addr, bus.sram_wdata);
        end
        next_cycle();
        bus.data_wr = 1'b0; bus.data_wstrb = 4'b0000; bus.data_wdata = '0;
        @(negedge clk);
        checks++;
        if ({bus.data_addr_ok, bus.sram_we, bus.data_data_ok} !== {1'b1, 4'b0000, 1'b1}) begin
            failures++; $display("FAIL read_accept_write_ack ok=%b we=%b ack=%b exp 1 0000 1", bus.data_addr_ok, bus.sram_we, bus.data_data_ok);
        end
        next_cycle();
        bus.data_req = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.data_data_ok !== 1'b1 || bus.data_rdata !== 32'h1234BEEF) begin
            failures++; $display("FAIL read_after_write ok=%b data=%h exp ok=1 data=1234beef", bus.data_data_ok, bus.data_rdata);
        end
        next_cycle();
    endtask

    task automatic test_starvation();
        logic prev_i;
        logic exp_i;
        prev_i = 1'b0;
        bus.inst_req = 1'b1; bus.inst_addr = 32'h1c000000;
        bus.data_req = 1'b1; bus.data_wr = 1'b0; bus.data_addr = 32'h100;
        for (int i = 0; i < 15; i++) begin
            exp_i = ((i % 5) == 4);
            @(negedge clk);
            checks++;
            if ({bus.inst_addr_ok, bus.data_addr_ok} !== {exp_i, !exp_i}) begin
                failures++; $display("FAIL starve_grant[%0d] got I=%b D=%b exp I=%b D=%b", i, bus.inst_addr_ok, bus.data_addr_ok, exp_i, !exp_i);
            end
            checks++;
            if (dut.starve_cnt !== 3'(i % 5)) begin
                failures++; $display("FAIL starve_cnt[%0d] got=%0d exp=%0d", i, dut.starve_cnt, i % 5);
            end
            if (i > 0) begin
                checks++;
                if ({bus.inst_data_ok, bus.data_data_ok} !== {prev_i, !prev_i}) begin
                    failures++; $display("FAIL starve_resp[%0d] got I=%b D=%b exp I=%b D=%b", i, bus.inst_data_ok, bus.data_data_ok, prev_i, !prev_i);
                end
            end
            prev_i = exp_i;
            next_cycle();
        end
        idle_inputs();
        next_cycle();
    endtask

    task automatic test_data_pulse();
        bus.inst_req = 1'b1; bus.inst_addr = 32'h1c000004;
        bus.data_req = 1'b1; bus.data_wr = 1'b0; bus.data_addr = 32'h100;
        for (int i = 0; i < 4; i++) begin
            if (i == 2) bus.data_req = 1'b0;
            if (i == 3) bus.inst_req = 1'b0;
            @(negedge clk);
            if (i < 3) begin
                checks++;
                if ({bus.inst_addr_ok, bus.data_addr_ok} !== ((i < 2) ? 2'b01 : 2'b10)) begin
                    failures++; $display("FAIL pulse_grant[%0d] got=%b exp=%b", i, {bus.inst_addr_ok, bus.data_addr_ok}, (i < 2) ? 2'b01 : 2'b10);
                end
            end
            checks++;
            if (dut.starve_cnt !== ((i == 3) ? 3'd0 : 3'(i))) begin
                failures++; $display("FAIL pulse_starve_cnt[%0d] got=%0d exp=%0d", i, dut.starve_cnt, (i == 3) ? 0 : i);
            end
            next_cycle();
        end
    endtask

    task automatic test_reset_midop();
        bus.inst_req = 1'b1; bus.inst_addr = 32'h1c000008;
        @(negedge clk);
        checks++;
        if (bus.inst_addr_ok !== 1'b1) begin
            failures++; $display("FAIL midrst_accept got=%b exp=1", bus.inst_addr_ok);
        end
        next_cycle();
        #1 resetn = 1'b0;
        #1;
        checks++;
        if (all_outputs() !== '0) begin
            failures++; $display("FAIL midrst_outputs got=%h exp=0", all_outputs());
        end
        next_cycle();
        checks++;
        if (all_outputs() !== '0) begin
            failures++; $display("FAIL midrst_held got=%h exp=0", all_outputs());
        end
        resetn = 1'b1;
        bus.inst_req = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if ({bus.inst_data_ok, bus.data_data_ok} !== 2'b00) begin
                failures++; $display("FAIL midrst_no_resp[%0d] got=%b exp=00", i, {bus.inst_data_ok, bus.data_data_ok});
            end
            next_cycle();
        end
        bus.inst_req = 1'b1; bus.inst_addr = 32'h1c000004;
        @(negedge clk);
        checks++;
        if (bus.inst_addr_ok !== 1'b1 || bus.sram_addr !== 32'h1c000004) begin
            failures++; $display("FAIL midrst_reaccept ok=%b addr=%h exp ok=1 addr=1c000004", bus.inst_addr_ok, bus.sram_addr);
        end
        next_cycle();
        bus.inst_req = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.inst_data_ok !== 1'b1 || bus.inst_rdata !== 32'hB1B1B1B1) begin
            failures++; $display("FAIL midrst_resp ok=%b data=%h exp ok=1 data=b1b1b1b1", bus.inst_data_ok, bus.inst_rdata);
        end
        next_cycle();
    endtask

    task automatic test_random_traffic();
        logic        i_acc, d_acc, exp_gi, exp_gd;
        logic        e_i, e_d, e_d_rd;
        logic [31:0] e_i_data, e_d_data;
        logic [2:0]  tcnt;
        i_acc = 1'b0; d_acc = 1'b0; e_i = 1'b0; e_d = 1'b0; e_d_rd = 1'b0;
        e_i_data = '0; e_d_data = '0; tcnt = 3'd0;
        for (int c = 0; c < 10000; c++) begin
            if (!bus.inst_req || i_acc) begin
                bus.inst_req  = ($urandom_range(0, 9) < 6);
                bus.inst_addr = 32'h200 + 32'($urandom_range(0, 15)) * 4;
            end
            if (!bus.data_req || d_acc) begin
                bus.data_req   = ($urandom_range(0, 9) < 6);
                bus.data_wr    = 1'($urandom_range(0, 1));
                bus.data_wstrb = 4'($urandom_range(0, 15));
                bus.data_addr  = 32'h200 + 32'($urandom_range(0, 15)) * 4;
                bus.data_wdata = $urandom;
            end
            exp_gd = bus.data_req && !(bus.inst_req && tcnt == 3'd4);
            exp_gi = bus.inst_req && !exp_gd;
            @(negedge clk);
            checks++;
            if ({bus.inst_addr_ok, bus.data_addr_ok} !== {exp_gi, exp_gd}) begin
                failures++; $display("FAIL rand_grant[%0d] got=%b exp=%b", c, {bus.inst_addr_ok, bus.data_addr_ok}, {exp_gi, exp_gd});
            end
            checks++;
            if ({bus.inst_data_ok, bus.data_data_ok} !== {e_i, e_d}) begin
                failures++; $display("FAIL rand_data_ok[%0d] got=%b exp=%b", c, {bus.inst_data_ok, bus.data_data_ok}, {e_i, e_d});
            end
            if (e_i) begin
                checks++;
                if (bus.inst_rdata !== e_i_data) begin
                    failures++; $display("FAIL rand_inst_rdata[%0d] got=%h exp=%h", c, bus.inst_rdata, e_i_data);
                end
            end
            if (e_d && e_d_rd) begin
                checks++;
                if (bus.data_rdata !== e_d_data) begin
                    failures++; $display("FAIL rand_data_rdata[%0d] got=%h exp=%h", c, bus.data_rdata, e_d_data);
                end
            end
            if (exp_gd && bus.data_wr) begin
                checks++;
                if (bus.sram_we !== bus.data_wstrb) begin
                    failures++; $display("FAIL rand_sram_we[%0d] got=%b exp=%b", c, bus.sram_we, bus.data_wstrb);
                end
            end
            i_acc = bus.inst_req && bus.inst_addr_ok;
            d_acc = bus.data_req && bus.data_addr_ok;
            e_i = i_acc;
            if (i_acc) e_i_data = refm[bus.inst_addr[11:2]];
            e_d = d_acc;
            e_d_rd = !bus.data_wr;
            if (d_acc) begin
                if (bus.data_wr) begin
                    for (int b = 0; b < 4; b++)
                        if (bus.data_wstrb[b]) refm[bus.data_addr[11:2]][8*b +: 8] = bus.data_wdata[8*b +: 8];
                end else begin
                    e_d_data = refm[bus.data_addr[11:2]];
                end
            end
            if (!bus.inst_req || i_acc) tcnt = 3'd0;
            else if (d_acc && tcnt != 3'd4) tcnt = tcnt + 3'd1;
            next_cycle();
        end
        idle_inputs();
        @(negedge clk);
        checks++;
        if ({bus.inst_data_ok, bus.data_data_ok} !== {e_i, e_d}) begin
            failures++; $display("FAIL rand_final_data_ok got=%b exp=%b", {bus.inst_data_ok, bus.data_data_ok}, {e_i, e_d});
        end
        next_cycle();
    endtask

    initial begin
        for (int unsigned k = 0; k < 1024; k++) begin
            mem[k]  = '0;
            refm[k] = '0;
        end
        mem[0]  = 32'hA0A0A0A0;
        mem[1]  = 32'hB1B1B1B1;
        mem[2]  = 32'hC2C2C2C2;
        mem[64] = 32'h12345678;
        idle_inputs();
        test_reset();
        test_inst_fetch();
        test_write_read();
        test_starvation();
        test_data_pulse();
        test_reset_midop();
        test_random_traffic();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
